// File: rtl/mfm_pkg.sv
// Shared constants and types for the MFM receive path.
package mfm_pkg;

  localparam logic [15:0] SYNC_A1_CELLS = 16'h4489;
  localparam logic [7:0]  SYNC_A1_BYTE  = 8'hA1;

  typedef enum logic {
    HUNT,
    SYNCED
  } state_e;

endpackage

// File: rtl/mfm_clock_check.sv
// Splits a 16-cell MFM window into its data byte and flags any clock cell that breaks
// the rule clock = NOR(previous data, following data).
module mfm_clock_check (
  input  logic [15:0] win_i,
  input  logic        last_data_i,
  output logic [7:0]  data_o,
  output logic        violation_o
);

  logic prev;

  always_comb begin
    data_o      = '0;
    violation_o = 1'b0;
    prev        = last_data_i;
    // Walk from the oldest pair; each clock cell sits between two data cells.
    for (int i = 7; i >= 0; i--) begin
      data_o[i] = win_i[2*i];
      if (win_i[2*i+1] != ~(prev | win_i[2*i])) begin
        violation_o = 1'b1;
      end
      prev = win_i[2*i];
    end
  end

endmodule

// File: rtl/mfm_decoder.sv
// MFM cell deframer: hunts for the A1 address mark, then emits one decoded byte per
// 16 consumed cells, dropping lock on repeated clock-rule violations or an index pulse.
module mfm_decoder
  import mfm_pkg::*;
#(
  parameter logic [15:0] SYNC_PATTERN = SYNC_A1_CELLS,
  parameter int unsigned MAX_ERRORS   = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk5,
  input  logic             rst_n,
  input  logic             cell_en,
  input  logic             mfm_in,
  input  logic             track_sync,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             is_mark,
  output logic             code_error,
  output logic             synced,
  output logic [CNT_W-1:0] byte_count
);

  state_e           state_q, state_d;
  logic [15:0]      win_q, win_d, win_next;
  logic [3:0]       cell_cnt_q, cell_cnt_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic             last_data_q, last_data_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             is_mark_q, is_mark_d;
  logic             code_error_q, code_error_d;
  logic             synced_q, synced_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;

  logic [7:0]       dec_data;
  logic             dec_violation;

  assign win_next = {win_q[14:0], mfm_in};

  mfm_clock_check u_clock_check (
    .win_i       (win_next),
    .last_data_i (last_data_q),
    .data_o      (dec_data),
    .violation_o (dec_violation)
  );

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    cell_cnt_d   = cell_cnt_q;
    err_cnt_d    = err_cnt_q;
    last_data_d  = last_data_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    is_mark_d    = is_mark_q;
    code_error_d = code_error_q;
    byte_count_d = byte_count_q;

    if (track_sync) begin
      // Index pulse wins over any cell on the same edge; the partial byte is dropped.
      state_d    = HUNT;
      cell_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (cell_en) begin
      win_d = win_next;
      case (state_q)
        HUNT: begin
          if (win_next == SYNC_PATTERN) begin
            state_d      = SYNCED;
            byte_valid_d = 1'b1;
            byte_out_d   = SYNC_A1_BYTE;
            is_mark_d    = 1'b1;
            code_error_d = 1'b0;
            byte_count_d = CNT_W'(1);
            cell_cnt_d   = '0;
            err_cnt_d    = '0;
            last_data_d  = win_next[0];
          end
        end
        SYNCED: begin
          if (cell_cnt_q == 4'd15) begin
            cell_cnt_d   = '0;
            byte_valid_d = 1'b1;
            byte_out_d   = dec_data;
            last_data_d  = win_next[0];
            if (byte_count_q != '1) begin
              byte_count_d = byte_count_q + CNT_W'(1);
            end
            if (win_next == SYNC_PATTERN) begin
              is_mark_d    = 1'b1;
              code_error_d = 1'b0;
              err_cnt_d    = '0;
            end else begin
              is_mark_d    = 1'b0;
              code_error_d = dec_violation;
              if (dec_violation) begin
                err_cnt_d = err_cnt_q + 4'd1;
                if (err_cnt_d == 4'(MAX_ERRORS)) begin
                  state_d   = HUNT;
                  err_cnt_d = '0;
                end
              end else begin
                err_cnt_d = '0;
              end
            end
          end else begin
            cell_cnt_d = cell_cnt_q + 4'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    synced_d = (state_d == SYNCED);
  end

  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      win_q        <= '0;
      cell_cnt_q   <= '0;
      err_cnt_q    <= '0;
      last_data_q  <= 1'b0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      is_mark_q    <= 1'b0;
      code_error_q <= 1'b0;
      synced_q     <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      cell_cnt_q   <= cell_cnt_d;
      err_cnt_q    <= err_cnt_d;
      last_data_q  <= last_data_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      is_mark_q    <= is_mark_d;
      code_error_q <= code_error_d;
      synced_q     <= synced_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign is_mark    = is_mark_q;
  assign code_error = code_error_q;
  assign synced     = synced_q;
  assign byte_count = byte_count_q;

endmodule

// File: doc/mfm_decoder.md
Name: mfm_decoder

Overview:
- Receive-side counterpart of the track MFM serializer.
- Samples one MFM cell per enabled clk5 edge and hunts for the A1 address mark (missing-clock pattern 16'h4489).
- Once locked, deframes 16-cell windows into data bytes, checks the MFM clock rule, and drops lock after repeated violations or an index pulse.
- Feeds the sector header/data parser.

Parameters:
- SYNC_PATTERN, 16'h4489, cell pattern of the address mark (decodes to 8'hA1).
- MAX_ERRORS, 4, consecutive code-error bytes that force loss of sync (1..15).
- CNT_W, 16, width of byte_count.

Ports:
- clk5  input  1  cell-rate clock; one clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- cell_en  input  1  qualifies mfm_in; a cell is consumed only on edges where cell_en=1.
- mfm_in  input  1  serial MFM cell, MSB (clock cell) first.
- track_sync  input  1  index/restart; forces HUNT.
- byte_out  output  8  decoded data byte.
- byte_valid  output  1  one-cycle strobe; byte_out, is_mark and code_error are valid with it.
- is_mark  output  1  byte came from a window equal to SYNC_PATTERN.
- code_error  output  1  byte's window violated the MFM clock rule.
- synced  output  1  high in SYNCED state.
- byte_count  output  CNT_W  bytes emitted since last sync acquisition; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, shift register 0, state HUNT, cell_cnt 0, err_cnt 0, last_data 0.
- Shift: on edge with cell_en=1, win_next = {win[14:0], mfm_in}; win <= win_next. No shift when cell_en=0; all counters hold.
- Data bits are win bits 14,12,..,0, MSB first. Clock bits are 15,13,..,1.
- All outputs are registered. Decision uses win_next, so byte_valid is high in the cycle after the edge that sampled the 16th cell. byte_valid is 0 on every other cycle.
- HUNT:
  - Compare win_next to SYNC_PATTERN on every consumed cell.
  - On match: go SYNCED; emit byte_valid=1, byte_out=8'hA1, is_mark=1, code_error=0.
  - Also on match: byte_count=1, cell_cnt=0, err_cnt=0, last_data=win_next[0].
- SYNCED:
  - cell_cnt counts 0..15 and wraps. On the 16th cell, emit a byte decoded from win_next.
  - If win_next==SYNC_PATTERN: is_mark=1, code_error=0, err_cnt=0.
  - Otherwise, clock rule: each clock bit must equal NOR(previous data bit, following data bit). The previous data bit of the first pair is last_data. Any mismatch gives code_error=1; err_cnt += 1; otherwise err_cnt=0.
  - The byte is emitted even when code_error=1.
  - last_data <= win_next[0]. byte_count increments, saturating.
  - If err_cnt reaches MAX_ERRORS on this byte: the erroring byte is still emitted; next state HUNT; synced drops the following cycle.
- Sync patterns appearing off a byte boundary while SYNCED are ignored (no realignment).
- track_sync=1 has priority over cell_en:
  - Next state HUNT; partial byte discarded (no byte_valid); cell_cnt, err_cnt cleared.
  - win is not updated that edge; byte_count holds until next acquisition.
- synced = (state==SYNCED), registered.

Decomposition:
- Package mfm_pkg: SYNC_A1_CELLS=16'h4489, SYNC_A1_BYTE=8'hA1, state enum {HUNT, SYNCED}.
- Sub-module mfm_clock_check (combinational): inputs 16-bit window and last_data; outputs data byte and violation flag. Reusable by a future write-verify path.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately; after release, no byte_valid until 16'h4489 is seen.
- Acquisition: random cells then 4489, 2AAA, 5555 with cell_en=1 -> bytes A1 (mark), 00, FF; code_error=0; byte_count 1,2,3; synced=1 after the first byte.
- Clock error: 4489 then AAAA -> byte 00 with code_error=1; then 2AAA after a clean byte -> err_cnt cleared.
- Loss of sync: 4489 then four FFFF windows -> four bytes FF with code_error=1; synced=0 after the 4th; a following 2AAA produces no byte_valid.
- cell_en gaps: 4489, 2AAA with cell_en toggled randomly -> same bytes, byte_valid one cycle after the 16th enabled cell only.
- track_sync mid-byte after 8 cells of 5555 -> no byte_valid, synced=0; next 4489 reacquires with byte_count=1.
